// File: rtl/wb_stage_if.sv
// Bundles the MEM->WB handshake, the data-SRAM response, the register-file write port and the debug trace.
// Carries signals only; it adds no logic and no latency.
// Backpressure is ws_allowin, driven by the stage on the slave modport.
interface wb_stage_if;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [2:0]  ms_ld_op;
    logic [1:0]  ms_addr_lo;
    logic [31:0] ms_result;
    logic        ws_flush;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  ws_fwd_dest;
    logic        ws_fwd_stall;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    // Upstream / environment side: drives MEM fields, flush and the SRAM response.
    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op, ms_addr_lo, ms_result,
        output ws_flush, data_sram_data_ok, data_sram_rdata,
        input  ws_allowin, rf_we, rf_waddr, rf_wdata, ws_fwd_dest, ws_fwd_stall,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    // The write-back stage itself.
    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op, ms_addr_lo, ms_result,
        input  ws_flush, data_sram_data_ok, data_sram_rdata,
        output ws_allowin, rf_we, rf_waddr, rf_wdata, ws_fwd_dest, ws_fwd_stall,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, waits for its load response, aligns/extends and writes the RF.
// Latency: non-loads write the cycle after acceptance; loads write in the data_ok cycle (bypass) or next if buffered.
// Backpressure: ws_allowin drops while a held load has no data; responses of flushed loads are discarded by count.
module wb_stage (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  wb
);

    logic        ws_valid;
    logic [31:0] ws_pc;
    logic        ws_gr_we;
    logic [4:0]  ws_dest;
    logic [2:0]  ws_ld_op;
    logic [1:0]  ws_addr_lo;
    logic [31:0] ws_result;
    logic [31:0] data_buf;
    logic        data_got;
    logic [1:0]  discard_cnt;

    logic        is_load;
    logic        resp_ok;
    logic        ws_ready_go;
    logic        accept;
    logic        load_wait;
    logic        kill_pending;
    logic        wr_en;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [1:0]  lwl_sh;
    logic [31:0] wdata_fmt;
    logic [3:0]  we_fmt;

    assign is_load      = ws_ld_op != 3'd0;
    // A response only belongs to the held load once all responses of killed loads are drained.
    assign resp_ok      = wb.data_sram_data_ok && (discard_cnt == 2'd0);
    assign ws_ready_go  = !is_load || data_got || resp_ok;
    assign wb.ws_allowin = !ws_valid || ws_ready_go;
    assign accept       = wb.ms_to_ws_valid && wb.ws_allowin && !wb.ws_flush;
    assign load_wait    = ws_valid && is_load && !data_got;
    // A flushed load whose response is still in flight leaves one response to throw away.
    assign kill_pending = wb.ws_flush && load_wait && !resp_ok;
    assign wr_en        = ws_valid && ws_ready_go && ws_gr_we && (ws_dest != 5'd0) && !wb.ws_flush;

    // Valid bit: flush kills, accept loads, retirement empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (wb.ws_flush) begin
            ws_valid <= 1'b0;
        end else if (accept) begin
            ws_valid <= 1'b1;
        end else if (ws_ready_go) begin
            ws_valid <= 1'b0;
        end
    end

    // Latch the instruction fields on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_pc      <= 32'd0;
            ws_gr_we   <= 1'b0;
            ws_dest    <= 5'd0;
            ws_ld_op   <= 3'd0;
            ws_addr_lo <= 2'd0;
            ws_result  <= 32'd0;
        end else if (accept) begin
            ws_pc      <= wb.ms_pc;
            ws_gr_we   <= wb.ms_gr_we;
            ws_dest    <= wb.ms_dest;
            ws_ld_op   <= wb.ms_ld_op;
            ws_addr_lo <= wb.ms_addr_lo;
            ws_result  <= wb.ms_result;
        end
    end

    // Buffer a response that cannot retire this cycle because a flush is blocking it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_buf <= 32'd0;
            data_got <= 1'b0;
        end else if (accept) begin
            data_got <= 1'b0;
        end else if (load_wait && resp_ok && wb.ws_flush) begin
            data_buf <= wb.data_sram_rdata;
            data_got <= 1'b1;
        end
    end

    // Count responses owed by killed loads; a drop and a new kill in one cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            discard_cnt <= 2'd0;
        end else if (wb.data_sram_data_ok && (discard_cnt != 2'd0)) begin
            if (!kill_pending) begin
                discard_cnt <= discard_cnt - 2'd1;
            end
        end else if (kill_pending && (discard_cnt != 2'd3)) begin
            discard_cnt <= discard_cnt + 2'd1;
        end
    end

    // Align and extend load data into the byte lanes the register file merges.
    always_comb begin
        ld_data   = data_got ? data_buf : wb.data_sram_rdata;
        ld_byte   = 8'd0;
        ld_half   = ws_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        lwl_sh    = 2'd3 - ws_addr_lo;
        wdata_fmt = ws_result;
        we_fmt    = 4'b1111;
        case (ws_addr_lo)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        case (ws_ld_op)
            3'd1: wdata_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd2: wdata_fmt = {24'd0, ld_byte};
            3'd3: wdata_fmt = {{16{ld_half[15]}}, ld_half};
            3'd4: wdata_fmt = {16'd0, ld_half};
            3'd5: wdata_fmt = ld_data;
            3'd6: begin
                wdata_fmt = ld_data << {lwl_sh, 3'b000};
                case (ws_addr_lo)
                    2'd0:    we_fmt = 4'b1000;
                    2'd1:    we_fmt = 4'b1100;
                    2'd2:    we_fmt = 4'b1110;
                    default: we_fmt = 4'b1111;
                endcase
            end
            3'd7: begin
                wdata_fmt = ld_data >> {ws_addr_lo, 3'b000};
                case (ws_addr_lo)
                    2'd0:    we_fmt = 4'b1111;
                    2'd1:    we_fmt = 4'b0111;
                    2'd2:    we_fmt = 4'b0011;
                    default: we_fmt = 4'b0001;
                endcase
            end
            default: wdata_fmt = ws_result;
        endcase
    end

    assign wb.rf_we             = wr_en ? we_fmt : 4'b0000;
    assign wb.rf_waddr          = ws_valid ? ws_dest : 5'd0;
    assign wb.rf_wdata          = ws_valid ? wdata_fmt : 32'd0;
    assign wb.ws_fwd_dest       = (ws_valid && ws_gr_we) ? ws_dest : 5'd0;
    assign wb.ws_fwd_stall      = ws_valid && !ws_ready_go;
    assign wb.debug_wb_pc       = ws_pc;
    assign wb.debug_wb_rf_wen   = wb.rf_we;
    assign wb.debug_wb_rf_wnum  = wb.rf_waddr;
    assign wb.debug_wb_rf_wdata = wb.rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps then a randomized run against a transaction-level model.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
// The memory model returns one tagged response per accepted load, in order, at random delays.
module tb_wb_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if bus();
    wb_stage dut (.clk(clk), .reset(reset), .wb(bus));

    int tests = 0;
    int fails = 0;

    // Model of the held instruction and outstanding responses.
    logic        m_valid, m_gr_we, m_got;
    logic [4:0]  m_dest;
    logic [2:0]  m_ld;
    logic [1:0]  m_a;
    logic [31:0] m_result, m_pc, m_gotdata;
    int          m_id, next_id;
    logic [31:0] rq_dat[$];
    int          rq_id[$];
    logic        dok, stale, fl, mv, match, rdy, e_allow;
    logic [2:0]  n_ld;
    logic [1:0]  n_a;
    logic [4:0]  n_dest;
    logic [31:0] d_use;
    logic [3:0]  ewe;
    logic [31:0] ewd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic gw, input logic [4:0] dst, input logic [2:0] ld,
                       input logic [1:0] a, input logic [31:0] res, input logic [31:0] pc);
        bus.ms_to_ws_valid = v;
        bus.ms_gr_we       = gw;
        bus.ms_dest        = dst;
        bus.ms_ld_op       = ld;
        bus.ms_addr_lo     = a;
        bus.ms_result      = res;
        bus.ms_pc          = pc;
    endtask

    task automatic resp(input logic ok, input logic [31:0] d);
        bus.data_sram_data_ok = ok;
        bus.data_sram_rdata   = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".we"},     bus.rf_we, 4'b0000);
        chk({tag, ".fwd"},    bus.ws_fwd_dest, 5'd0);
        chk({tag, ".stall"},  bus.ws_fwd_stall, 1'b0);
        chk({tag, ".allow"},  bus.ws_allowin, 1'b1);
        chk({tag, ".dbgpc"},  bus.debug_wb_pc, 32'd0);
        chk({tag, ".dbgwen"}, bus.debug_wb_rf_wen, 4'b0000);
        chk({tag, ".dbgwd"},  bus.debug_wb_rf_wdata, 32'd0);
        chk({tag, ".dbgwn"},  bus.debug_wb_rf_wnum, 5'd0);
    endtask

    // Load accepted, response offered in the very next cycle; expectations given as constants.
    task automatic load_now(input string tag, input logic [2:0] ld, input logic [1:0] a,
                            input logic [31:0] d, input logic [3:0] xwe, input logic [31:0] xwd);
        put(1'b1, 1'b1, 5'd7, ld, a, 32'h0, 32'h0000_0200);
        tick();
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        resp(1'b1, d);
        @(negedge clk);
        chk({tag, ".we"},    bus.rf_we, xwe);
        chk({tag, ".wdata"}, bus.rf_wdata, xwd);
        chk({tag, ".waddr"}, bus.rf_waddr, 5'd7);
        tick();
        resp(1'b0, 32'h0);
    endtask

    // Byte/halfword/partial-word rules written as plain arithmetic on lane numbers.
    function automatic void ref_wb(input int ld, input int a, input logic [31:0] d, input logic [31:0] res,
                                   output logic [3:0] we, output logic [31:0] wd);
        logic [31:0] b;
        logic [31:0] h;
        we = 4'b1111;
        b  = (d >> (8 * a)) & 32'hFF;
        h  = (d >> (16 * (a / 2))) & 32'hFFFF;
        case (ld)
            0: wd = res;
            1: wd = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            2: wd = b;
            3: wd = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4: wd = h;
            5: wd = d;
            6: begin
                wd = d << (8 * (3 - a));
                for (int i = 0; i < 4; i++) we[i] = (i >= 3 - a);
            end
            default: begin
                wd = d >> (8 * a);
                for (int i = 0; i < 4; i++) we[i] = (i <= 3 - a);
            end
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        resp(1'b0, 32'h0);
        bus.ws_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Back-to-back non-loads.
        put(1'b1, 1'b1, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 32'h0000_0100);
        tick();
        put(1'b1, 1'b1, 5'd6, 3'd0, 2'd0, 32'h0000_1111, 32'h0000_0104);
        @(negedge clk);
        chk("addu.we",    bus.rf_we, 4'b1111);
        chk("addu.waddr", bus.rf_waddr, 5'd5);
        chk("addu.wdata", bus.rf_wdata, 32'h1234_5678);
        chk("addu.allow", bus.ws_allowin, 1'b1);
        chk("addu.pc",    bus.debug_wb_pc, 32'h0000_0100);
        chk("addu.fwd",   bus.ws_fwd_dest, 5'd5);
        tick();
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("addu2.we",    bus.rf_we, 4'b1111);
        chk("addu2.waddr", bus.rf_waddr, 5'd6);
        chk("addu2.wdata", bus.rf_wdata, 32'h0000_1111);
        tick();
        @(negedge clk);
        chk("drain.we", bus.rf_we, 4'b0000);
        tick();

        // Load alignment cases.
        load_now("lb",  3'd1, 2'd3, 32'h80FF_0011, 4'b1111, 32'hFFFF_FF80);
        load_now("lbu", 3'd2, 2'd3, 32'h80FF_0011, 4'b1111, 32'h0000_0080);
        load_now("lh",  3'd3, 2'd2, 32'h80FF_0011, 4'b1111, 32'hFFFF_80FF);
        load_now("lwl", 3'd6, 2'd1, 32'hAABB_CCDD, 4'b1100, 32'hCCDD_0000);
        load_now("lwr", 3'd7, 2'd2, 32'hAABB_CCDD, 4'b0011, 32'h0000_AABB);

        // Load whose response arrives after three waiting cycles.
        put(1'b1, 1'b1, 5'd8, 3'd5, 2'd0, 32'h0, 32'h0000_0300);
        tick();
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait.stall", bus.ws_fwd_stall, 1'b1);
            chk("wait.allow", bus.ws_allowin, 1'b0);
            chk("wait.we",    bus.rf_we, 4'b0000);
            tick();
        end
        resp(1'b1, 32'hDEAD_BEEF);
        put(1'b1, 1'b1, 5'd9, 3'd0, 2'd0, 32'h0000_0055, 32'h0000_0304);
        @(negedge clk);
        chk("late.we",    bus.rf_we, 4'b1111);
        chk("late.wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("late.allow", bus.ws_allowin, 1'b1);
        chk("late.stall", bus.ws_fwd_stall, 1'b0);
        tick();
        resp(1'b0, 32'h0);
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("follow.waddr", bus.rf_waddr, 5'd9);
        chk("follow.wdata", bus.rf_wdata, 32'h0000_0055);
        tick();

        // Flush a pending load; its response must be dropped.
        put(1'b1, 1'b1, 5'd10, 3'd5, 2'd0, 32'h0, 32'h0000_0400);
        tick();
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        bus.ws_flush = 1'b1;
        @(negedge clk);
        chk("flush.we", bus.rf_we, 4'b0000);
        tick();
        bus.ws_flush = 1'b0;
        put(1'b1, 1'b1, 5'd11, 3'd5, 2'd0, 32'h0, 32'h0000_0404);
        tick();
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        resp(1'b1, 32'hBAD0_BAD0);
        @(negedge clk);
        chk("stale.we",    bus.rf_we, 4'b0000);
        chk("stale.stall", bus.ws_fwd_stall, 1'b1);
        tick();
        resp(1'b1, 32'h600D_F00D);
        @(negedge clk);
        chk("own.we",    bus.rf_we, 4'b1111);
        chk("own.wdata", bus.rf_wdata, 32'h600D_F00D);
        chk("own.waddr", bus.rf_waddr, 5'd11);
        tick();
        resp(1'b0, 32'h0);

        // Reset in the middle of a load.
        put(1'b1, 1'b1, 5'd12, 3'd5, 2'd0, 32'h0, 32'h0000_0500);
        tick();
        put(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("preRst.stall", bus.ws_fwd_stall, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk_idle("midRst");
        tick();
        reset = 1'b0;
        load_now("postRst", 3'd5, 2'd0, 32'h0BAD_CAFE, 4'b1111, 32'h0BAD_CAFE);

        // Randomized run against the transaction-level model.
        m_valid = 1'b0; m_got = 1'b0; m_gr_we = 1'b0; m_dest = 5'd0; m_ld = 3'd0; m_a = 2'd0;
        m_result = 32'h0; m_pc = 32'h0; m_gotdata = 32'h0; m_id = -1; next_id = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dok   = (rq_dat.size() != 0) && ($urandom % 3 == 0);
            stale = dok && !(m_valid && (m_ld != 3'd0) && !m_got && (rq_id[0] == m_id));
            fl    = ($urandom % 8 == 0) && !stale && (rq_dat.size() <= 2);
            mv    = ($urandom % 2) == 1;
            n_ld  = 3'($urandom % 8);
            n_a   = 2'($urandom % 4);
            if (n_ld == 3'd3 || n_ld == 3'd4) n_a[0] = 1'b0;
            n_dest = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom % 32);
            put(mv, 1'($urandom % 4 != 0), n_dest, n_ld, n_a, $urandom, $urandom);
            resp(dok, dok ? rq_dat[0] : $urandom);
            bus.ws_flush = fl;

            match   = dok && !stale;
            rdy     = (m_ld == 3'd0) || m_got || match;
            e_allow = !m_valid || rdy;
            d_use   = m_got ? m_gotdata : (match ? rq_dat[0] : 32'h0);
            ewe     = 4'b0000;
            ewd     = 32'h0;
            if (m_valid && rdy && m_gr_we && (m_dest != 5'd0) && !fl)
                ref_wb(int'(m_ld), int'(m_a), d_use, m_result, ewe, ewd);

            @(negedge clk);
            chk("rnd.allow", bus.ws_allowin, e_allow);
            chk("rnd.stall", bus.ws_fwd_stall, m_valid && !rdy);
            chk("rnd.fwd",   bus.ws_fwd_dest, (m_valid && m_gr_we) ? m_dest : 5'd0);
            chk("rnd.we",    bus.rf_we, ewe);
            chk("rnd.dwen",  bus.debug_wb_rf_wen, ewe);
            if (ewe != 4'b0000) begin
                chk("rnd.wdata", bus.rf_wdata, ewd);
                chk("rnd.waddr", bus.rf_waddr, m_dest);
                chk("rnd.pc",    bus.debug_wb_pc, m_pc);
            end

            if (dok) begin
                void'(rq_dat.pop_front());
                void'(rq_id.pop_front());
            end
            if (fl) begin
                if (match) begin
                    m_got     = 1'b1;
                    m_gotdata = d_use;
                end
                m_valid = 1'b0;
            end else if (bus.ms_to_ws_valid && e_allow) begin
                m_valid  = 1'b1;
                m_gr_we  = bus.ms_gr_we;
                m_dest   = bus.ms_dest;
                m_ld     = bus.ms_ld_op;
                m_a      = bus.ms_addr_lo;
                m_result = bus.ms_result;
                m_pc     = bus.ms_pc;
                m_got    = 1'b0;
                m_id     = next_id;
                next_id++;
                if (bus.ms_ld_op != 3'd0) begin
                    rq_dat.push_back($urandom);
                    rq_id.push_back(m_id);
                end
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back pipeline stage of the MIPS core. Accepts one instruction per handshake from the MEM stage and waits for the data-SRAM load response when needed. It then aligns and sign/zero-extends load data and drives the byte-enabled register-file write port (`we[3:0]`, `waddr`, `wdata`) plus the NSCSCC debug trace. Partial-register loads (LWL/LWR) are expressed as byte enables; the register file performs the merge.

## Interface
- No parameters.
- `clk` in 1: core clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `ms_to_ws_valid` in 1: MEM stage presents an instruction.
- `ws_allowin` out 1: WB can accept this cycle.
- `ms_pc` in 32: instruction PC.
- `ms_gr_we` in 1: instruction writes a GPR.
- `ms_dest` in 5: destination register.
- `ms_ld_op` in 3: 000 non-load, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWL, 111 LWR.
- `ms_addr_lo` in 2: load address bits [1:0].
- `ms_result` in 32: ALU/other result (non-load).
- `ws_flush` in 1: exception/eret flush; kills the WB instruction.
- `data_sram_data_ok` in 1: load response valid (one cycle per response).
- `data_sram_rdata` in 32: load response data.
- `rf_we` out 4: byte write enables to the register file.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: byte-positioned write data.
- `ws_fwd_dest` out 5: destination of the valid WB instruction; 0 if none or no write.
- `ws_fwd_stall` out 1: WB holds a load whose data has not arrived (ID must stall, not forward).
- `debug_wb_pc` out 32, `debug_wb_rf_wen` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: trace; equal to `ws_pc`/`rf_we`/`rf_waddr`/`rf_wdata`.

## Operation
- Registers: `ws_valid`, the latched ms_* fields, `data_buf[31:0]`, `data_got`, `discard_cnt[1:0]`.
- Ready: `ws_ready_go = (ld_op==0) | data_got | (data_sram_data_ok & discard_cnt==0)`. `ws_allowin = !ws_valid | ws_ready_go`.
- Accept: when `ms_to_ws_valid & ws_allowin & !ws_flush`, latch fields, set `ws_valid`, clear `data_got`. Otherwise a retiring instruction clears `ws_valid`.
- Response arriving while `discard_cnt!=0`: drop it and decrement the counter.
- Response arriving otherwise, with a load held and `!data_got`:
  - Same cycle as retire: the response is used directly via bypass.
  - Retire blocked only by flush: capture into `data_buf` and set `data_got`.
- Flush: `ws_valid` cleared next cycle; nothing is written in the flush cycle. If the killed instruction is a load with `!data_got` and no response this cycle, increment `discard_cnt`.
- Write: `rf_we` is nonzero only when `ws_valid & ws_ready_go & ms_gr_we & dest!=0 & !ws_flush`. Let d = data, a = addr_lo:
  - non-load: we=1111, wdata=result.
  - LB/LBU: byte d[8a+7:8a], sign/zero-extended; we=1111.
  - LH/LHU: halfword at a[1]; sign/zero-extended; we=1111. a[0]=1 is excluded by the upstream exception logic.
  - LW: d; we=1111.
  - LWL: wdata = d << 8*(3-a); we = {1000,1100,1110,1111}[a].
  - LWR: wdata = d >> 8*a; we = {1111,0111,0011,0001}[a].
- `rf_waddr` = latched dest, whenever `ws_valid`.

## Timing
- Reset values:
  - `ws_valid=0`, `data_got=0`, `discard_cnt=0`, `data_buf=0`, latched fields 0.
  - Outputs: `rf_we=0`, `ws_fwd_dest=0`, `ws_fwd_stall=0`, `ws_allowin=1`, debug outputs 0.
- Non-load: write occurs in the cycle after acceptance; 1 instruction/cycle throughput.
- Load: write occurs in the cycle `data_ok` is seen (bypass, 0 added latency), or the cycle after acceptance if the data is already buffered.
- Write outputs are combinational from state and the `data_ok`/`flush` inputs; the register file commits on the next edge.
- Flush and accept in the same cycle: flush wins; the incoming instruction is not latched.
- `discard_cnt` saturates at 3. A reset mid-load clears it; responses after reset are the memory side's responsibility.

## Test plan
- ADDU result 0x12345678 to r5 -> one cycle with `rf_we`=1111, `rf_waddr`=5, `rf_wdata`=0x12345678; back-to-back non-loads retire every cycle.
- LB, a=3, d=0x80FF0011 -> `rf_wdata`=0xFFFFFF80, we=1111. LBU, same inputs -> 0x00000080. LH, a=2 -> 0xFFFF80FF.
- LWL, a=1, d=0xAABBCCDD -> we=1100, wdata=0xCCDD0000. LWR, a=2 -> we=0011, wdata=0x0000AABB.
- Load with `data_ok` 3 cycles after acceptance -> `ws_fwd_stall`=1 and `ws_allowin`=0 for 3 cycles; write in the `data_ok` cycle; a following instruction is accepted that same cycle.
- Flush while a load is pending -> no write. The next `data_ok` is dropped (`discard_cnt` 1→0). The following load writes only its own response data.
- Reset asserted mid-load -> all outputs return to their reset values immediately; `ws_allowin`=1.
